gametank_cpu_sdram_bridge: RTL and testbench

Bus responder for the CPU's SDRAM/cart window. It turns CPU accesses qualified by the BCU chip enable into handshaked SDRAM requests on the o_cpumem_* side of the GameTank top. It drives the CPU pause (Rdy) line while a read is outstanding. It also posts writes, keeps a one-entry read cache, and enforces a timeout so that a dead memory cannot hang the CPU.

---
 rtl/gametank_cpu_sdram_bridge.sv | 165 ++++++++++++++++
 tb/tb_gametank_cpu_sdram_bridge.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gametank_cpu_sdram_bridge.sv
// CPU-side responder for the SDRAM/cart window. Converts BCU-qualified CPU
// accesses into level-held memory requests, stalls the CPU while a read is
// outstanding, posts writes, keeps a single-byte read cache, and abandons any
// access whose acknowledge never arrives.
module gametank_cpu_sdram_bridge #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [7:0]  OPEN_BUS = 8'hFF,
  parameter int unsigned BANK_W   = 8
) (
  input  logic              i_clk_cpu,
  input  logic              i_reset_n,
  input  logic              i_ce,
  input  logic              i_rnw,
  input  logic [15:0]       i_addr,
  input  logic [7:0]        i_data_in,
  input  logic [BANK_W-1:0] i_bank,
  output logic [7:0]        o_data_out,
  output logic              o_pause,
  output logic [21:0]       o_mem_addr,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [7:0]        o_mem_dout,
  input  logic [7:0]        i_mem_din,
  input  logic              i_mem_ack,
  output logic              o_timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2,
    WR_WAIT = 2'd3
  } state_t;

  // Last count value before an unacknowledged request is given up.
  localparam logic [7:0] TCOUNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  tcount;
  logic [7:0]  data_q;
  logic        cache_valid;
  logic [21:0] cache_tag;
  logic [7:0]  cache_data;

  logic [21:0] ea;
  logic        cache_hit;
  logic        expired;
  logic        hit_now;
  logic        pause_c;
  logic        unused_addr_hi;

  // The window is 16 KiB per bank, so the top two CPU address bits never
  // reach memory; the bank register supplies the upper address instead.
  assign ea             = 22'({i_bank, i_addr[13:0]});
  assign unused_addr_hi = ^i_addr[15:14];

  assign cache_hit = cache_valid && (cache_tag == ea);
  assign expired   = (tcount == TCOUNT_LAST);
  assign hit_now   = (state == IDLE) && i_ce && i_rnw && cache_hit;

  // A cache hit is served in the same cycle; otherwise the last captured
  // byte is held until a new read completes.
  assign o_data_out = hit_now ? cache_data : data_q;

  // Stall the CPU for a read miss in IDLE and for any access that arrives
  // while memory is still busy; RD_DONE is the cycle the CPU takes the data.
  always_comb begin
    pause_c = 1'b0;
    if (i_reset_n && i_ce) begin
      case (state)
        IDLE:    pause_c = i_rnw && !cache_hit;
        RD_WAIT: pause_c = 1'b1;
        WR_WAIT: pause_c = 1'b1;
        default: pause_c = 1'b0;
      endcase
    end
  end

  assign o_pause = pause_c;

  // Access sequencer: launches requests, waits for ack or expiry, and
  // maintains the one-entry read cache.
  always_ff @(posedge i_clk_cpu or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      tcount      <= 8'd0;
      data_q      <= 8'hFF;
      cache_valid <= 1'b0;
      cache_tag   <= 22'd0;
      cache_data  <= 8'd0;
      o_mem_addr  <= 22'd0;
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
      o_mem_dout  <= 8'd0;
      o_timeout   <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (i_ce) begin
            if (i_rnw) begin
              if (cache_hit) begin
                data_q <= cache_data;
              end else begin
                o_mem_read <= 1'b1;
                o_mem_addr <= ea;
                tcount     <= 8'd0;
                state      <= RD_WAIT;
              end
            end else begin
              o_mem_write <= 1'b1;
              o_mem_addr  <= ea;
              o_mem_dout  <= i_data_in;
              tcount      <= 8'd0;
              state       <= WR_WAIT;
            end
          end
        end

        RD_WAIT: begin
          if (i_mem_ack) begin
            o_mem_read  <= 1'b0;
            data_q      <= i_mem_din;
            cache_valid <= 1'b1;
            cache_tag   <= o_mem_addr;
            cache_data  <= i_mem_din;
            state       <= RD_DONE;
          end else if (expired) begin
            o_mem_read <= 1'b0;
            data_q     <= OPEN_BUS;
            o_timeout  <= 1'b1;
            state      <= RD_DONE;
          end else begin
            tcount <= tcount + 8'd1;
          end
        end

        RD_DONE: begin
          state <= IDLE;
        end

        WR_WAIT: begin
          if (i_mem_ack) begin
            o_mem_write <= 1'b0;
            if (cache_tag == o_mem_addr) begin
              cache_data <= o_mem_dout;
            end
            state <= IDLE;
          end else if (expired) begin
            o_mem_write <= 1'b0;
            o_timeout   <= 1'b1;
            state       <= IDLE;
          end else begin
            tcount <= tcount + 8'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gametank_cpu_sdram_bridge.sv
// Scoreboard bench for the CPU/SDRAM bridge: a CPU-like driver issues accesses,
// a reference model predicts requests and CPU-visible results into queues, a
// memory responder acknowledges with chosen latencies, and a monitor compares.
module tb_gametank_cpu_sdram_bridge;

  localparam int         TIMEOUT  = 64;
  localparam logic [7:0] OPEN_BUS = 8'hFF;
  localparam int         BANK_W   = 8;

  logic              i_clk_cpu = 1'b0;
  logic              i_reset_n = 1'b0;
  logic              i_ce = 1'b0;
  logic              i_rnw = 1'b1;
  logic [15:0]       i_addr = 16'd0;
  logic [7:0]        i_data_in = 8'd0;
  logic [BANK_W-1:0] i_bank = '0;
  logic [7:0]        o_data_out;
  logic              o_pause;
  logic [21:0]       o_mem_addr;
  logic              o_mem_read;
  logic              o_mem_write;
  logic [7:0]        o_mem_dout;
  logic [7:0]        i_mem_din;
  logic              i_mem_ack;
  logic              o_timeout;

  gametank_cpu_sdram_bridge #(
    .TIMEOUT (TIMEOUT),
    .OPEN_BUS(OPEN_BUS),
    .BANK_W  (BANK_W)
  ) dut (
    .i_clk_cpu  (i_clk_cpu),
    .i_reset_n  (i_reset_n),
    .i_ce       (i_ce),
    .i_rnw      (i_rnw),
    .i_addr     (i_addr),
    .i_data_in  (i_data_in),
    .i_bank     (i_bank),
    .o_data_out (o_data_out),
    .o_pause    (o_pause),
    .o_mem_addr (o_mem_addr),
    .o_mem_read (o_mem_read),
    .o_mem_write(o_mem_write),
    .o_mem_dout (o_mem_dout),
    .i_mem_din  (i_mem_din),
    .i_mem_ack  (i_mem_ack),
    .o_timeout  (o_timeout)
  );

  always #5 i_clk_cpu = ~i_clk_cpu;

  int cycle = 0;
  always @(posedge i_clk_cpu) cycle <= cycle + 1;

  typedef struct {
    bit          wr;
    logic [21:0] addr;
    logic [7:0]  data;
    int          len;
    bit          to;
  } req_t;

  typedef struct {
    bit         rd;
    logic [7:0] data;
    int         stall;
  } acc_t;

  req_t exp_req[$];
  acc_t exp_acc[$];
  int   lat_q[$];

  int checks = 0;
  int errors = 0;
  int to_expected = 0;
  int to_seen = 0;
  bit poke_ack = 1'b0;

  // Reference model: one cached byte, a sparse memory image, and the first
  // cycle at which the bridge is free to accept a new access.
  bit          ref_valid = 1'b0;
  logic [21:0] ref_tag = 22'd0;
  logic [7:0]  ref_data = 8'd0;
  int          free_at = 0;
  logic [7:0]  ref_mem[int];
  logic [7:0]  sdram[int];

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a * 37 + (a >>> 9)) ^ 8'h96;
  endfunction

  function automatic logic [7:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predict one access issued at cycle t: which memory request it causes, how
  // long the CPU is held, and what byte it sees.
  task automatic modelAccess(input bit rnw, input int bank, input int addr, input logic [7:0] data,
                             input int lat, input int t, input bit record);
    logic [21:0] ea;
    int          start;
    bit          to;
    int          len;
    logic [7:0]  rd;
    ea    = 22'(bank * 16384 + (addr % 16384));
    start = (t > free_at) ? t : free_at;
    to    = (lat < 1) || (lat > TIMEOUT);
    len   = to ? TIMEOUT : lat;
    if (rnw && ref_valid && ref_tag == ea) begin
      if (record) exp_acc.push_back('{1'b1, ref_data, start - t});
      free_at = start;
    end else if (rnw) begin
      exp_req.push_back('{1'b0, ea, 8'h00, len, to});
      lat_q.push_back(lat);
      if (to) begin
        to_expected++;
        rd = OPEN_BUS;
      end else begin
        rd        = ref_read(int'(ea));
        ref_valid = 1'b1;
        ref_tag   = ea;
        ref_data  = rd;
      end
      if (record) exp_acc.push_back('{1'b1, rd, start - t + len + 1});
      free_at = start + len + 2;
    end else begin
      exp_req.push_back('{1'b1, ea, data, len, to});
      lat_q.push_back(lat);
      if (to) begin
        to_expected++;
      end else begin
        ref_mem[int'(ea)] = data;
        if (ref_tag == ea) ref_data = data;
      end
      if (record) exp_acc.push_back('{1'b0, 8'h00, start - t});
      free_at = start + len + 1;
    end
  endtask

  // CPU-like driver: entered just after a rising edge; holds the access until
  // the bridge releases pause (or abandons it after 'drop' cycles).
  task automatic applyStimulus(input bit rnw, input int bank, input int addr, input logic [7:0] data,
                               input int lat, input int gap, input int drop);
    int n;
    bit stuck;
    i_ce      = 1'b1;
    i_rnw     = rnw;
    i_bank    = BANK_W'(bank);
    i_addr    = 16'(addr);
    i_data_in = data;
    modelAccess(rnw, bank, addr, data, lat, cycle, drop == 0);
    n     = 0;
    stuck = 1'b0;
    if (drop == 0) begin
      forever begin
        @(negedge i_clk_cpu);
        if (!o_pause) break;
        n++;
        if (n > 400) begin
          stuck = 1'b1;
          break;
        end
      end
      checkOutput("pause_release_bound", 32'(stuck), 32'd0);
      @(posedge i_clk_cpu);
      #1;
    end else begin
      repeat (drop) begin
        @(posedge i_clk_cpu);
        #1;
      end
      i_ce   = 1'b0;
      i_bank = BANK_W'($urandom);
      while (cycle < free_at && n < 400) begin
        @(posedge i_clk_cpu);
        #1;
        n++;
      end
    end
    i_ce      = 1'b0;
    i_rnw     = 1'($urandom);
    i_addr    = 16'($urandom);
    i_data_in = 8'($urandom);
    repeat (gap) begin
      @(posedge i_clk_cpu);
      #1;
    end
  endtask

  // Memory responder: acknowledges each request after its chosen latency
  // (0 = never), and drives junk on i_mem_din outside the ack cycle.
  initial begin
    bit active;
    int cnt;
    int cur_lat;
    active    = 1'b0;
    cnt       = 0;
    cur_lat   = 0;
    i_mem_ack = 1'b0;
    i_mem_din = 8'd0;
    forever begin
      @(posedge i_clk_cpu);
      #1;
      if (!i_reset_n) begin
        active    = 1'b0;
        i_mem_ack = 1'b0;
      end else if (o_mem_read || o_mem_write) begin
        if (!active) begin
          active  = 1'b1;
          cnt     = 0;
          cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 2;
        end
        cnt++;
        if (cur_lat != 0 && cnt == cur_lat) begin
          i_mem_ack = 1'b1;
          if (o_mem_write) begin
            sdram[int'(o_mem_addr)] = o_mem_dout;
            i_mem_din = 8'($urandom);
          end else begin
            i_mem_din = sdram.exists(int'(o_mem_addr)) ? sdram[int'(o_mem_addr)]
                                                        : init_byte(int'(o_mem_addr));
          end
        end else begin
          i_mem_ack = 1'b0;
          i_mem_din = 8'($urandom);
        end
      end else begin
        active    = 1'b0;
        i_mem_ack = poke_ack;
        i_mem_din = 8'($urandom);
      end
    end
  end

  // Monitor: pops expected requests on request rise, checks their length and
  // timeout outcome on fall, and pops expected CPU results on pause release.
  initial begin
    bit          prev_req;
    bit          prev_to;
    int          dur;
    int          stall;
    logic [21:0] last_addr;
    req_t        cur;
    acc_t        a;
    prev_req  = 1'b0;
    prev_to   = 1'b0;
    dur       = 0;
    stall     = 0;
    last_addr = 22'd0;
    cur       = '{1'b0, 22'd0, 8'd0, -1, 1'b0};
    forever begin
      @(negedge i_clk_cpu);
      if (!i_reset_n) begin
        prev_req = 1'b0;
        prev_to  = 1'b0;
        dur      = 0;
        stall    = 0;
        continue;
      end
      if (o_mem_read || o_mem_write) begin
        if (!prev_req) begin
          checkOutput("req_exclusive", 32'(o_mem_read & o_mem_write), 32'd0);
          if (exp_req.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_req actual=addr %0h expected=none", o_mem_addr);
            cur = '{1'b0, 22'd0, 8'd0, -1, 1'b0};
          end else begin
            cur = exp_req.pop_front();
            checkOutput("req_kind", 32'(o_mem_write), 32'(cur.wr));
            checkOutput("req_addr", 32'(o_mem_addr), 32'(cur.addr));
            if (cur.wr) checkOutput("req_wdata", 32'(o_mem_dout), 32'(cur.data));
          end
          dur = 0;
        end
        dur++;
        last_addr = o_mem_addr;
        prev_req  = 1'b1;
      end else if (prev_req) begin
        checkOutput("req_len", 32'(dur), 32'(cur.len));
        checkOutput("req_timeout_flag", 32'(o_timeout), 32'(cur.to));
        checkOutput("req_addr_held", 32'(last_addr), 32'(cur.addr));
        prev_req = 1'b0;
      end
      if (o_timeout) begin
        to_seen++;
        checkOutput("timeout_width", 32'(prev_to), 32'd0);
      end
      prev_to = o_timeout;
      if (i_ce) begin
        if (o_pause) begin
          stall++;
        end else begin
          if (exp_acc.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_completion actual=data %0h expected=none", o_data_out);
          end else begin
            a = exp_acc.pop_front();
            checkOutput("stall_cycles", 32'(stall), 32'(a.stall));
            if (a.rd) checkOutput("read_data", 32'(o_data_out), 32'(a.data));
          end
          stall = 0;
        end
      end else begin
        stall = 0;
      end
    end
  end

  // Watchdog so a wedged run still ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pause"}, 32'(o_pause), 32'd0);
    checkOutput({tag, "_mem_read"}, 32'(o_mem_read), 32'd0);
    checkOutput({tag, "_mem_write"}, 32'(o_mem_write), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(o_mem_addr), 32'd0);
    checkOutput({tag, "_mem_dout"}, 32'(o_mem_dout), 32'd0);
    checkOutput({tag, "_data_out"}, 32'(o_data_out), 32'hFF);
    checkOutput({tag, "_timeout"}, 32'(o_timeout), 32'd0);
  endtask

  int pool[6] = '{16'h0123, 16'h0010, 16'h0200, 16'h0456, 16'h0777, 16'h3FFF};

  initial begin
    logic [21:0] xea;
    int          r;
    int          lat;
    int          n;

    ref_mem[32'h123] = 8'h5A;
    sdram[32'h123]   = 8'h5A;

    repeat (3) @(posedge i_clk_cpu);
    #3;
    i_reset_n = 1'b1;
    @(negedge i_clk_cpu);
    checkResetValues("reset");
    free_at = cycle;
    @(posedge i_clk_cpu);
    #1;

    $display("[TB] directed accesses");
    applyStimulus(1'b1, 0, 16'h0123, 8'h00, 3, 0, 0);          // miss, 5A
    applyStimulus(1'b1, 0, 16'h0123, 8'h00, 3, 0, 0);          // hit
    applyStimulus(1'b0, 0, 16'h0123, 8'hC3, 2, 0, 0);          // posted write
    applyStimulus(1'b1, 0, 16'h0123, 8'h00, 1, 0, 0);          // hit on updated byte
    applyStimulus(1'b0, 2, 16'h8010, 8'h77, 4, 0, 0);          // write EA 008010
    applyStimulus(1'b1, 1, 16'h0200, 8'h00, 2, 2, 0);          // miss behind write
    applyStimulus(1'b1, 3, 16'h0456, 8'h00, 0, 1, 0);          // read timeout
    applyStimulus(1'b1, 3, 16'h0456, 8'h00, 1, 1, 0);          // misses again
    applyStimulus(1'b1, 0, 16'h0777, 8'h00, TIMEOUT, 0, 0);    // ack at expiry wins
    applyStimulus(1'b0, 0, 16'h0777, 8'h3C, TIMEOUT + 1, 0, 0); // write timeout
    applyStimulus(1'b1, 0, 16'h0777, 8'h00, 1, 0, 0);          // cache untouched
    applyStimulus(1'b1, 2, 16'hC010, 8'h00, 5, 0, 2);          // ce dropped mid-read
    applyStimulus(1'b1, 2, 16'h0010, 8'h00, 1, 0, 0);          // hit from that fill

    $display("[TB] reset during read wait");
    n = 0;
    while (cycle < free_at && n < 400) begin
      @(posedge i_clk_cpu);
      #1;
      n++;
    end
    xea = 22'(8'h7F * 16384 + 16'h1234);
    exp_req.push_back('{1'b0, xea, 8'h00, 0, 1'b0});
    lat_q.push_back(0);
    i_ce   = 1'b1;
    i_rnw  = 1'b1;
    i_bank = BANK_W'(8'h7F);
    i_addr = 16'h1234;
    repeat (3) @(posedge i_clk_cpu);
    #3;
    i_reset_n = 1'b0;
    #1;
    checkResetValues("midreset");
    i_ce = 1'b0;
    @(posedge i_clk_cpu);
    #3;
    i_reset_n = 1'b1;
    @(negedge i_clk_cpu);
    poke_ack = 1'b1;
    @(negedge i_clk_cpu);
    poke_ack = 1'b0;
    @(negedge i_clk_cpu);
    checkOutput("post_ack_mem_read", 32'(o_mem_read), 32'd0);
    checkOutput("post_ack_data_out", 32'(o_data_out), 32'hFF);
    checkOutput("post_ack_timeout", 32'(o_timeout), 32'd0);
    ref_valid = 1'b0;
    ref_tag   = 22'd0;
    free_at   = cycle;
    @(posedge i_clk_cpu);
    #1;
    applyStimulus(1'b1, 8'h7F, 16'h1234, 8'h00, 2, 0, 0);      // must miss

    $display("[TB] randomized accesses");
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom % 100);
      if (r < 4)      lat = 0;
      else if (r < 6) lat = TIMEOUT;
      else if (r < 8) lat = TIMEOUT + 1;
      else            lat = 1 + int'($urandom % 6);
      applyStimulus(($urandom % 3) != 0,
                    int'($urandom % 4),
                    int'($urandom % 4) * 16384 + pool[$urandom % 6],
                    8'($urandom),
                    lat,
                    int'($urandom % 3),
                    0);
    end

    repeat (80) @(posedge i_clk_cpu);
    @(negedge i_clk_cpu);
    checkOutput("leftover_requests", 32'(exp_req.size()), 32'd0);
    checkOutput("leftover_accesses", 32'(exp_acc.size()), 32'd0);
    checkOutput("timeout_count", 32'(to_seen), 32'(to_expected));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
